// File: rtl/down4_sched_pkg.sv
// down4_sched_pkg
//   Shared definitions for the down4_sched countdown scheduler:
//   - state_t   : scheduler FSM states (IDLE, COUNT, DONE)
//   - NREQ_DEF  : default number of requesters
//   - W_DEF     : default countdown width in bits
package down4_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;

endpackage

// File: rtl/down4_sched_rr_arb.sv
// rr_arb
//   Combinational round-robin selector. The search starts one position past
//   the last winner and wraps modulo NREQ; the first requester found wins.
// Ports:
//   req      in   NREQ   request vector
//   last     in   IW     index of the previous winner
//   win_oh   out  NREQ   one-hot winner (all-zero when no request)
//   win_idx  out  IW     winner index (0 when no request)
//   any      out  1      at least one request is pending
module rr_arb
  import down4_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic          found_s;
  logic [IW-1:0] cand_s;

  assign any = |req;

  // Rotating priority scan: candidate k is (last + 1 + k) mod NREQ.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IW'((int'(last) + 1 + k) % NREQ);
      if (req[cand_s] && !found_s) begin
        found_s         = 1'b1;
        win_oh[cand_s]  = 1'b1;
        win_idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/down4_sched.sv
// down4_sched
//   Shares one countdown resource among NREQ requesters. An idle scheduler
//   grants the next requester in round-robin order, loads Q with that
//   requester's length and counts down to zero, then pulses done for one
//   cycle. Dropping the owner's request mid-count aborts without done.
// Ports:
//   CLK    in   1        clock, rising edge
//   Reset  in   1        asynchronous active-high reset
//   req    in   NREQ     per-requester level request
//   len    in   NREQ*W   per-requester length, slice i = len[i*W +: W]
//   gnt    out  NREQ     one-hot grant (registered)
//   done   out  NREQ     one-cycle completion pulse (registered)
//   busy   out  1        state is not IDLE
//   Q      out  W        current countdown value (registered)
module down4_sched
  import down4_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      Q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_r;
  logic [W-1:0]    q_r;
  logic [NREQ-1:0] gnt_r;
  logic [NREQ-1:0] done_r;
  logic [IW-1:0]   owner_r;
  logic [IW-1:0]   last_r;

  logic [NREQ-1:0] win_oh_s;
  logic [IW-1:0]   win_idx_s;
  logic            any_s;
  logic [W-1:0]    len_sel_s;

  rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arb (
    .req     (req),
    .last    (last_r),
    .win_oh  (win_oh_s),
    .win_idx (win_idx_s),
    .any     (any_s)
  );

  // Length slice of the current round-robin winner, muxed by its one-hot grant.
  always_comb begin
    len_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh_s[i]) begin
        len_sel_s = len[i*W +: W];
      end else begin
        len_sel_s = len_sel_s;
      end
    end
  end

  // Scheduler FSM with countdown register and registered grant/done outputs.
  // last_r resets to NREQ-1 so the first search after reset starts at 0.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      q_r     <= '1;
      gnt_r   <= '0;
      done_r  <= '0;
      owner_r <= '0;
      last_r  <= IW'(NREQ - 1);
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            // len is sampled only here; later changes do not affect the count
            state_r <= COUNT;
            gnt_r   <= win_oh_s;
            owner_r <= win_idx_s;
            last_r  <= win_idx_s;
            q_r     <= len_sel_s;
          end else begin
            state_r <= IDLE;
          end
        end
        COUNT: begin
          if (!req[owner_r]) begin
            // Abort: Q holds, no done pulse, owner still counts as last winner
            state_r <= IDLE;
            gnt_r   <= '0;
          end else if (q_r == '0) begin
            state_r <= DONE;
            done_r  <= gnt_r;
          end else begin
            q_r <= q_r - W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          gnt_r   <= '0;
          done_r  <= '0;
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= '0;
          done_r  <= '0;
        end
      endcase
    end
  end

  assign gnt  = gnt_r;
  assign done = done_r;
  assign Q    = q_r;
  assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_down4_sched.sv
// tb_down4_sched
//   Self-checking bench for down4_sched (NREQ = 4, W = 4). A transaction-level
//   model tracks the current owner, its sampled length and the edges elapsed
//   since the grant; expected outputs are derived from those by arithmetic and
//   compared against the DUT on every falling edge. Directed scenarios add
//   literal expectations, then a randomized phase exercises the rest.
module tb_down4_sched;

  localparam int N  = 4;
  localparam int WL = 4;

  logic            CLK = 1'b0;
  logic            Reset;
  logic [N-1:0]    req;
  logic [N*WL-1:0] len;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            busy;
  logic [WL-1:0]   Q;

  int n_chk  = 0;
  int n_pass = 0;

  down4_sched #(.NREQ(N), .W(WL)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .Q     (Q)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic setlen(input int i, input int v);
    len[i*WL +: WL] = WL'(v);
  endtask

  // ---------------- behavioural model ----------------
  bit m_own   = 1'b0;  // a requester currently holds the resource
  int m_w     = 0;     // owner index
  int m_L     = 0;     // length sampled at grant
  int m_k     = 0;     // edges elapsed since the grant edge
  int m_q     = 15;    // Q while nobody owns the resource
  int m_start = 0;     // where the next round-robin search begins

  function automatic int pick(input logic [N-1:0] r, input int s);
    for (int j = 0; j < N; j++) begin
      if (r[(s + j) % N]) return (s + j) % N;
    end
    return 0;
  endfunction

  function automatic int len_of(input logic [N*WL-1:0] l, input int i);
    return int'(l[i*WL +: WL]);
  endfunction

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_own   <= 1'b0;
      m_q     <= 15;
      m_start <= 0;
      m_k     <= 0;
    end else if (!m_own) begin
      if (req != '0) begin
        m_own   <= 1'b1;
        m_w     <= pick(req, m_start);
        m_L     <= len_of(len, pick(req, m_start));
        m_k     <= 0;
        m_start <= (pick(req, m_start) + 1) % N;
      end
    end else if (m_k <= m_L) begin
      if (!req[m_w]) begin
        m_own <= 1'b0;
        m_q   <= m_L - m_k;
      end else begin
        m_k <= m_k + 1;
      end
    end else begin
      m_own <= 1'b0;
      m_q   <= 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    chk("cyc_gnt",  int'(gnt),  m_own ? (1 << m_w) : 0);
    chk("cyc_done", int'(done), (m_own && m_k == m_L + 1) ? (1 << m_w) : 0);
    chk("cyc_busy", int'(busy), int'(m_own));
    chk("cyc_q",    int'(Q),    m_own ? ((m_k <= m_L) ? (m_L - m_k) : 0) : m_q);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int exp_g[5];
    int ng;
    int gap;
    bit prev;
    exp_g = '{1, 2, 4, 8, 1};
    req   = '0;
    len   = '0;
    Reset = 1'b0;
    #1 Reset = 1'b1;
    #1;
    chk("rst_q", int'(Q), 15);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;

    // Single request, len 3
    req = 4'b0001; setlen(0, 3);
    @(negedge CLK); chk("t1_gnt", int'(gnt), 1); chk("t1_q3", int'(Q), 3);
    @(negedge CLK); chk("t1_q2", int'(Q), 2);
    @(negedge CLK); chk("t1_q1", int'(Q), 1);
    @(negedge CLK); chk("t1_q0", int'(Q), 0); chk("t1_nodone", int'(done), 0);
    @(negedge CLK); chk("t1_done", int'(done), 1); chk("t1_qd", int'(Q), 0);
    req = 4'b0000;
    @(negedge CLK); chk("t1_idle_gnt", int'(gnt), 0); chk("t1_idle_busy", int'(busy), 0);
    chk("t1_idle_q", int'(Q), 0);

    // Contention after a fresh reset
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < N; i++) setlen(i, 1);
    ng = 0; gap = 0; prev = 1'b0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      @(negedge CLK);
      if (gnt != '0 && !prev) begin
        chk("t2_order", int'(gnt), exp_g[ng]);
        if (ng > 0) chk("t2_gap", gap, 1);
        ng++;
        gap = 0;
      end else if (gnt == '0) begin
        gap++;
      end
      prev = (gnt != '0);
    end
    chk("t2_count", ng, 5);
    req = 4'b0000;
    repeat (3) @(negedge CLK);

    // Zero length on requester 2
    req = 4'b0100; setlen(2, 0);
    @(negedge CLK); chk("t3_gnt", int'(gnt), 4); chk("t3_q", int'(Q), 0);
    chk("t3_nodone", int'(done), 0);
    @(negedge CLK); chk("t3_done", int'(done), 4); chk("t3_qd", int'(Q), 0);
    req = 4'b0000;
    @(negedge CLK); chk("t3_idle", int'(gnt), 0);

    // Abort requester 1 at Q = 3
    req = 4'b0010; setlen(1, 5);
    @(negedge CLK); chk("t4_gnt", int'(gnt), 2); chk("t4_q5", int'(Q), 5);
    @(negedge CLK); chk("t4_q4", int'(Q), 4);
    @(negedge CLK); chk("t4_q3", int'(Q), 3);
    req = 4'b0000;
    @(negedge CLK); chk("t4_ab_gnt", int'(gnt), 0); chk("t4_ab_done", int'(done), 0);
    chk("t4_ab_q", int'(Q), 3); chk("t4_ab_busy", int'(busy), 0);
    @(negedge CLK); chk("t4_hold_q", int'(Q), 3);
    req = 4'b1111;
    for (int i = 0; i < N; i++) setlen(i, 2);
    @(negedge CLK); chk("t4_next_rr", int'(gnt), 4);
    req = 4'b0000;
    repeat (2) @(negedge CLK);

    // Reset mid-count at Q = 2
    req = 4'b0001; setlen(0, 4);
    @(negedge CLK); chk("t5_gnt", int'(gnt), 1); chk("t5_q4", int'(Q), 4);
    @(negedge CLK);
    @(negedge CLK); chk("t5_q2", int'(Q), 2);
    #2 Reset = 1'b1;
    #1;
    chk("t5_rst_q", int'(Q), 15);
    chk("t5_rst_gnt", int'(gnt), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_done", int'(done), 0);
    @(negedge CLK);
    Reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < N; i++) setlen(i, 1);
    @(negedge CLK); chk("t5_rr_restart", int'(gnt), 1);
    req = 4'b0000;
    repeat (2) @(negedge CLK);

    // Length change after grant is ignored
    req = 4'b0001; setlen(0, 3);
    @(negedge CLK); chk("t6_gnt", int'(gnt), 1); chk("t6_q3", int'(Q), 3);
    setlen(0, 9);
    @(negedge CLK); chk("t6_q2", int'(Q), 2);
    @(negedge CLK); chk("t6_q1", int'(Q), 1);
    @(negedge CLK); chk("t6_q0", int'(Q), 0);
    @(negedge CLK); chk("t6_done", int'(done), 1); chk("t6_qd", int'(Q), 0);
    req = 4'b0000;
    @(negedge CLK); chk("t6_idle", int'(gnt), 0);

    // Randomized phase, checked by the per-cycle model comparison
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      Reset = ($urandom_range(99, 0) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7, 0) == 0) req[i] = ~req[i];
        if ($urandom_range(3, 0) == 0) setlen(i, $urandom_range(6, 0));
      end
    end
    Reset = 1'b0;
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
